// File: rtl/ctrl_pkg.sv
// Shared types for the APB initiator: command record, FSM state encoding
// and the default bus widths.
package ctrl_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  function automatic apb_cmd_t make_cmd(input logic                  write,
                                        input logic [APB_ADDR_W-1:0] addr,
                                        input logic [APB_DATA_W-1:0] wdata);
    apb_cmd_t c;
    c.write = write;
    c.addr  = addr;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/apb_initiator_if.sv
// Command, response and APB bus signals of the initiator; master is the
// initiator's view, slave the view of its environment.
interface apb_initiator_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata,
    output cmd_ready, rsp_valid, rsp_rdata, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_initiator_cmd_fifo.sv
// Synchronous FIFO holding queued commands; pointers wrap modulo DEPTH,
// DEPTH must be a power of two.
module cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == {CNT_W{1'b0}});
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // storage array, contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1'b1);
        2'b01:   r_count <= r_count - CNT_W'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/apb_initiator.sv
// APB initiator: queues commands in a FIFO and replays them as APB
// SETUP/ACCESS pairs; read data is returned through a valid/ready response.
module apb_initiator
  import ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = APB_ADDR_W,
  parameter int unsigned DATA_W    = APB_DATA_W,
  parameter int unsigned CMD_DEPTH = 4
) (
  input  logic             pclk,
  input  logic             preset,
  apb_initiator_if.master  bus,
  output logic             busy
);
  localparam int unsigned CNT_W = $clog2(CMD_DEPTH) + 1;

  apb_state_e        r_state;
  apb_state_e        w_state_nxt;
  apb_cmd_t          w_push_cmd;
  apb_cmd_t          w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic              r_psel,      w_psel_nxt;
  logic              r_penable,   w_penable_nxt;
  logic              r_pwrite,    w_pwrite_nxt;
  logic [ADDR_W-1:0] r_paddr,     w_paddr_nxt;
  logic [DATA_W-1:0] r_pwdata,    w_pwdata_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic              r_busy,      w_busy_nxt;

  // Gated by preset so no command is offered a slot while held in reset.
  assign bus.cmd_ready = ~w_full & preset;
  assign w_push        = bus.cmd_valid & bus.cmd_ready;
  assign w_push_cmd    = make_cmd(bus.cmd_write, bus.cmd_addr, bus.cmd_wdata);

  cmd_fifo #(
    .WIDTH ($bits(apb_cmd_t)),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk     (pclk),
    .rst_n   (preset),
    .i_push  (w_push),
    .i_data  (w_push_cmd),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // next state, FIFO pop and next values of every registered output
  always_comb begin
    w_state_nxt     = r_state;
    w_pop           = 1'b0;
    w_psel_nxt      = 1'b0;
    w_penable_nxt   = 1'b0;
    w_pwrite_nxt    = 1'b0;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_rdata_nxt = r_rsp_rdata;
    if (r_rsp_valid && bus.rsp_ready) begin
      w_rsp_valid_nxt = 1'b0;
    end else begin
      w_rsp_valid_nxt = r_rsp_valid;
    end

    case (r_state)
      ST_IDLE: begin
        // a pending response blocks new transfers so reads stay in order
        if (!w_empty && !r_rsp_valid) begin
          w_state_nxt  = ST_SETUP;
          w_pop        = 1'b1;
          w_psel_nxt   = 1'b1;
          w_pwrite_nxt = w_head.write;
          w_paddr_nxt  = w_head.addr;
          w_pwdata_nxt = w_head.wdata;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_SETUP: begin
        w_state_nxt   = ST_ACCESS;
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b1;
        w_pwrite_nxt  = r_pwrite;
      end
      ST_ACCESS: begin
        if (!r_pwrite) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = bus.prdata;
        end else begin
          w_rsp_rdata_nxt = r_rsp_rdata;
        end
        // only writes chain straight into the next SETUP
        if (r_pwrite && !w_empty) begin
          w_state_nxt  = ST_SETUP;
          w_pop        = 1'b1;
          w_psel_nxt   = 1'b1;
          w_pwrite_nxt = w_head.write;
          w_paddr_nxt  = w_head.addr;
          w_pwdata_nxt = w_head.wdata;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_cnt_nxt  = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    w_busy_nxt = (w_state_nxt != ST_IDLE) || (w_cnt_nxt != {CNT_W{1'b0}});
  end

  // state and output registers
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_state     <= ST_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= {ADDR_W{1'b0}};
      r_pwdata    <= {DATA_W{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {DATA_W{1'b0}};
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.psel      = r_psel;
  assign bus.penable   = r_penable;
  assign bus.pwrite    = r_pwrite;
  assign bus.paddr     = r_paddr;
  assign bus.pwdata    = r_pwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign busy          = r_busy;
endmodule

// File: tb/tb_apb_initiator.sv
// Directed bench for apb_initiator: inputs change on the falling edge,
// outputs are sampled on the falling edge after each rising edge.
module tb_apb_initiator;
  logic pclk = 1'b0;
  logic preset;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;

  apb_initiator_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_initiator #(.ADDR_W(32), .DATA_W(32), .CMD_DEPTH(4)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 pclk = ~pclk;

  // responder: fixed pattern at 0x18, address-derived data elsewhere
  assign bus.prdata = (bus.paddr == 32'h0000_0018) ? 32'hDEAD_BEEF
                                                    : (bus.paddr ^ 32'hA5A5_0000);

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
  endtask

  logic [31:0] exp_w [4];
  logic [63:0] ref_q [$];
  logic [63:0] exp_cmd;
  int run, max_run, n_acc, psel_cnt, pushed, seen;
  logic saw_full;

  initial begin
    exp_w = '{32'h11, 32'h22, 32'h33, 32'h44};
    preset        = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.rsp_ready = 1'b0;

    // reset values
    @(negedge pclk);
    check_eq("rst_psel",      64'(bus.psel),      64'd0);
    check_eq("rst_penable",   64'(bus.penable),   64'd0);
    check_eq("rst_pwrite",    64'(bus.pwrite),    64'd0);
    check_eq("rst_paddr",     64'(bus.paddr),     64'd0);
    check_eq("rst_pwdata",    64'(bus.pwdata),    64'd0);
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check_eq("rst_busy",      64'(busy),          64'd0);
    check_eq("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    preset = 1'b1;
    #1;
    check_eq("rel_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // single write 0x0 <- 0x107
    @(negedge pclk);
    drive_cmd(1'b1, 32'h0, 32'h0000_0107);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    check_eq("wr_n_psel", 64'(bus.psel), 64'd0);
    check_eq("wr_n_busy", 64'(busy),     64'd1);
    @(negedge pclk);
    check_eq("wr_n1_psel",    64'(bus.psel),    64'd1);
    check_eq("wr_n1_penable", 64'(bus.penable), 64'd0);
    check_eq("wr_n1_paddr",   64'(bus.paddr),   64'h0);
    check_eq("wr_n1_pwdata",  64'(bus.pwdata),  64'h107);
    check_eq("wr_n1_pwrite",  64'(bus.pwrite),  64'd1);
    @(negedge pclk);
    check_eq("wr_n2_psel",    64'(bus.psel),    64'd1);
    check_eq("wr_n2_penable", 64'(bus.penable), 64'd1);
    check_eq("wr_n2_pwdata",  64'(bus.pwdata),  64'h107);
    @(negedge pclk);
    check_eq("wr_n3_psel",    64'(bus.psel),    64'd0);
    check_eq("wr_n3_penable", 64'(bus.penable), 64'd0);
    check_eq("wr_n3_pwrite",  64'(bus.pwrite),  64'd0);
    check_eq("wr_n3_pwdata",  64'(bus.pwdata),  64'h107);
    check_eq("wr_n3_busy",    64'(busy),        64'd0);

    // read 0x18, response left pending
    drive_cmd(1'b0, 32'h18, 32'h0);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    @(negedge pclk);
    check_eq("rd_n1_psel",   64'(bus.psel),   64'd1);
    check_eq("rd_n1_pwrite", 64'(bus.pwrite), 64'd0);
    check_eq("rd_n1_paddr",  64'(bus.paddr),  64'h18);
    @(negedge pclk);
    check_eq("rd_n2_penable",   64'(bus.penable),   64'd1);
    check_eq("rd_n2_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge pclk);
    check_eq("rd_n3_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check_eq("rd_n3_rsp_rdata", 64'(bus.rsp_rdata), 64'hDEAD_BEEF);
    check_eq("rd_n3_psel",      64'(bus.psel),      64'd0);

    // four writes stalled behind the pending response fill the FIFO
    for (int k = 0; k < 4; k++) begin
      check_eq("fill_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      drive_cmd(1'b1, 32'h4, exp_w[k]);
      @(negedge pclk);
    end
    bus.cmd_valid = 1'b0;
    check_eq("full_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check_eq("full_psel",      64'(bus.psel),      64'd0);
    check_eq("full_rsp_rdata", 64'(bus.rsp_rdata), 64'hDEAD_BEEF);
    bus.rsp_ready = 1'b1;
    @(negedge pclk);
    bus.rsp_ready = 1'b0;
    check_eq("cons_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("cons_psel",      64'(bus.psel),      64'd0);
    run = 0; max_run = 0; n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge pclk);
      if (bus.psel) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (bus.psel && bus.penable) begin
        if (n_acc < 4) begin
          check_eq("b2b_paddr",  64'(bus.paddr),  64'h4);
          check_eq("b2b_pwdata", 64'(bus.pwdata), 64'(exp_w[n_acc]));
        end
        n_acc++;
      end
    end
    check_eq("b2b_psel_run",  64'(max_run),       64'd8);
    check_eq("b2b_accesses",  64'(n_acc),         64'd4);
    check_eq("b2b_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check_eq("b2b_busy",      64'(busy),          64'd0);

    // two reads, first response held for 10 cycles
    drive_cmd(1'b0, 32'h20, 32'h0);
    @(negedge pclk);
    drive_cmd(1'b0, 32'h24, 32'h0);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    check_eq("rr_first_valid", 64'(bus.rsp_valid), 64'd1);
    check_eq("rr_first_rdata", 64'(bus.rsp_rdata), 64'hA5A5_0020);
    psel_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      if (bus.psel) psel_cnt++;
    end
    check_eq("rr_stall_psel",  64'(psel_cnt),      64'd0);
    check_eq("rr_stall_rdata", 64'(bus.rsp_rdata), 64'hA5A5_0020);
    check_eq("rr_stall_busy",  64'(busy),          64'd1);
    bus.rsp_ready = 1'b1;
    @(negedge pclk);
    bus.rsp_ready = 1'b0;
    check_eq("rr_cons1_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge pclk);
    check_eq("rr_second_psel",  64'(bus.psel),  64'd1);
    check_eq("rr_second_paddr", 64'(bus.paddr), 64'h24);
    @(negedge pclk);
    check_eq("rr_second_penable", 64'(bus.penable), 64'd1);
    @(negedge pclk);
    check_eq("rr_second_valid", 64'(bus.rsp_valid), 64'd1);
    check_eq("rr_second_rdata", 64'(bus.rsp_rdata), 64'hA5A5_0024);
    bus.rsp_ready = 1'b1;
    @(negedge pclk);
    bus.rsp_ready = 1'b0;
    check_eq("rr_cons2_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rr_cons2_busy",  64'(busy),          64'd0);

    // reset during the ACCESS of a write with another write queued
    drive_cmd(1'b1, 32'h8, 32'h55);
    @(negedge pclk);
    drive_cmd(1'b1, 32'hC, 32'h66);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    check_eq("ab_setup_paddr", 64'(bus.paddr), 64'h8);
    @(negedge pclk);
    check_eq("ab_access_penable", 64'(bus.penable), 64'd1);
    preset = 1'b0;
    #1;
    check_eq("ab_psel",      64'(bus.psel),      64'd0);
    check_eq("ab_penable",   64'(bus.penable),   64'd0);
    check_eq("ab_paddr",     64'(bus.paddr),     64'd0);
    check_eq("ab_pwdata",    64'(bus.pwdata),    64'd0);
    check_eq("ab_busy",      64'(busy),          64'd0);
    check_eq("ab_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    @(negedge pclk);
    preset = 1'b1;
    psel_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      if (bus.psel) psel_cnt++;
    end
    check_eq("ab_after_psel",      64'(psel_cnt),      64'd0);
    check_eq("ab_after_busy",      64'(busy),          64'd0);
    check_eq("ab_after_rsp_valid", 64'(bus.rsp_valid), 64'd0);

    // write stream pushed whenever ready, checked against a reference queue
    pushed = 0; seen = 0; saw_full = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (bus.psel && bus.penable) begin
        exp_cmd = 64'hFFFF_FFFF_FFFF_FFFF;
        if (ref_q.size() != 0) begin
          exp_cmd = ref_q.pop_front();
        end else begin
          exp_cmd = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        check_eq("stream_cmd", {bus.paddr, bus.pwdata}, exp_cmd);
        seen++;
      end
      if (!bus.cmd_ready) saw_full = 1'b1;
      if (pushed < 10 && bus.cmd_ready) begin
        drive_cmd(1'b1, 32'h100 + 32'(4 * pushed), 32'hC0DE_0000 + 32'(pushed));
        ref_q.push_back({32'h100 + 32'(4 * pushed), 32'hC0DE_0000 + 32'(pushed)});
        pushed++;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      @(negedge pclk);
    end
    check_eq("stream_seen",     64'(seen),         64'd10);
    check_eq("stream_leftover", 64'(ref_q.size()), 64'd0);
    check_eq("stream_saw_full", 64'(saw_full),     64'd1);
    check_eq("stream_busy",     64'(busy),         64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
